ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 32-bit program RAM between the CPU data port and a host debug/readout port.
- Fixed CPU priority, with a starvation counter so the host is never locked out.
- Optional host lock gives the host back-to-back bursts for readout/serialization, bounded by a timeout.
- Sits between the CPU/host requesters and the RAM instance at the top level; the RAM has synchronous write and one-cycle registered read.

Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 32, RAM data width
- MAX_WAIT, 4, host stall cycles before the host wins priority (1..15)
- LOCK_MAX, 16, maximum cycles in host-locked state before forced release (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU transaction request; held until cpu_gnt
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU transaction accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- host_req  in  1  host request; held until host_gnt
- host_we  in  1  host write / read
- host_lock  in  1  keep ownership after this host transaction
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host transaction accepted
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
- locked  out  1  FSM in HOST_LOCKED

Behaviour:
- Reset values (async, immediate):
  - FSM=ARB, starve_cnt=0, lock_cnt=0, read tags cleared.
  - All gnt/rvalid/ram_we/locked=0.
  - ram_addr=0, ram_wdata=0.
- Handshake:
  - A transaction is accepted in the cycle where req&&gnt.
  - The requester keeps req/we/addr/wdata/lock stable until accepted; the arbiter never revokes a grant mid-cycle.
  - At most one gnt is high per cycle.
- Grants are combinational from req and registered state (zero-cycle grant).
- FSM ARB:
  - cpu_gnt = cpu_req && !(host_req && starve_cnt==MAX_WAIT).
  - host_gnt = host_req && !cpu_gnt.
  - Host accepted with host_lock=1 -> HOST_LOCKED, lock_cnt=0.
- FSM HOST_LOCKED:
  - cpu_gnt=0; host_gnt=host_req.
  - lock_cnt increments every cycle, saturating.
  - Host accepted with host_lock=0 -> ARB.
  - lock_cnt==LOCK_MAX-1 -> ARB next cycle, even if a locked transaction is accepted that cycle.
  - locked=1 in this state.
- starve_cnt:
  - host_req && !host_gnt -> increment, saturating at MAX_WAIT.
  - host_gnt or !host_req -> 0.
  - Not advanced in HOST_LOCKED.
- RAM mux:
  - The granted requester drives ram_we/ram_addr/ram_wdata.
  - No grant -> ram_we=0, addr=0, wdata=0.
- Read pipeline:
  - A granted read sets the owner's rd_pending register.
  - Next cycle the owner's rvalid=1 for exactly one cycle, with rdata=ram_rdata.
  - rdata=0 when rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle.
- Ordering:
  - Write granted at cycle t, read of the same address granted at t+1 -> the read returns the new data.
  - The arbiter adds no buffering, so the RAM order equals the grant order.
- Simultaneous requests, starve_cnt<MAX_WAIT -> CPU. Equal to MAX_WAIT -> host.
- Reset mid-operation: any pending rvalid is dropped (no response after reset); a locked FSM returns to ARB.

Decomposition:
- Shared package:
  - FSM state enum {ARB, HOST_LOCKED}.
  - Default widths ADDR_W/DATA_W, reused by the RAM and top level.
- Sub-module arb_rd_tracker: the per-requester rd_pending register plus rvalid/rdata gating.
  - Instantiated twice (cpu, host).
- Grant logic, counters and FSM stay in ram_arbiter.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 mid-read (cpu read granted at t, rst at t+1).
  - Required: cpu_rvalid never asserts; all outputs 0; after release, cpu_req gets gnt the same cycle.
- Write/read CPU:
  - Stimulus: cpu write addr 5 data 0xDEADBEEF, then cpu read addr 5 on the next cycle.
  - Required: ram_we=1 with addr 5 on cycle 1; cpu_rvalid=1 with rdata=0xDEADBEEF on cycle 3; host_rvalid=0 throughout.
- Contention/starvation:
  - Stimulus: cpu_req held continuously with reads, host read addr 2 asserted, MAX_WAIT=4.
  - Required: CPU granted 4 cycles; host_gnt on the 5th cycle; host_rvalid one cycle later with RAM[2]; CPU granted again the following cycle.
- Host lock burst:
  - Stimulus: host reads addr 0..3 with host_lock=1,1,1,0 while cpu_req is held.
  - Required: 4 consecutive host grants; locked=1 for cycles 2-4; first cpu_gnt in the cycle after the addr-3 grant.
- Lock timeout:
  - Stimulus: LOCK_MAX=16, host holds lock=1 with host_req toggling, cpu_req high.
  - Required: locked drops after 16 cycles; cpu_gnt in the next cycle.
- Mutual exclusion:
  - Stimulus: random req/we/lock on both ports for 10k cycles.
  - Required: never both gnt high; a response for every granted read arrives exactly 1 cycle later, tagged to the correct port; the RAM model matches the scoreboard.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default widths for the program-RAM arbiter and its RAM.
package ram_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic {
      ARB         = 1'b0,
      HOST_LOCKED = 1'b1
   } arb_state_e;

   // 8-bit increment that sticks at all-ones
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ram_arbiter_rd_tracker.sv
// Per-requester read tracker: remembers a granted read for one cycle and
// presents the RAM's registered read data to that requester only.
module arb_rd_tracker
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_accept,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   logic rd_pending_q, rd_pending_d;

   // a read accepted this cycle returns data next cycle
   always_comb begin
      rd_pending_d = rd_accept;
   end

   // pending flag; reset drops any outstanding response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending_q <= 1'b0;
      end else begin
         rd_pending_q <= rd_pending_d;
      end
   end

   // data is zeroed whenever this requester has no response
   always_comb begin
      rvalid = rd_pending_q;
      rdata  = rd_pending_q ? ram_rdata : '0;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single-port program RAM between the CPU data port and
// the host debug port: CPU priority, host anti-starvation, host lock bursts.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned LOCK_MAX = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic              host_lock,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              locked
);

   localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

   arb_state_e state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic [7:0] lock_cnt_q, lock_cnt_d;
   logic       cpu_rd_acc, host_rd_acc;

   // zero-cycle grants; nothing is granted while reset is asserted
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (!rst) begin
         if (state_q == HOST_LOCKED) begin
            host_gnt = host_req;
         end else begin
            cpu_gnt  = cpu_req && !(host_req && (starve_cnt_q == WAIT_LIM));
            host_gnt = host_req && !cpu_gnt;
         end
      end
   end

   // granted requester drives the RAM; idle bus is all zeros
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (cpu_gnt) begin
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
      end else if (host_gnt) begin
         ram_we    = host_we;
         ram_addr  = host_addr;
         ram_wdata = host_wdata;
      end
   end

   // next state for the FSM, starvation and lock counters
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      case (state_q)
         ARB: begin
            if (host_req && !host_gnt) begin
               starve_cnt_d = (starve_cnt_q >= WAIT_LIM) ? WAIT_LIM : starve_cnt_q + 4'd1;
            end else begin
               starve_cnt_d = '0;
            end
            if (host_gnt && host_lock) begin
               state_d    = HOST_LOCKED;
               lock_cnt_d = '0;
            end
         end
         HOST_LOCKED: begin
            lock_cnt_d = sat_inc8(lock_cnt_q);
            // timeout wins even when a locked transaction is accepted this cycle
            if ((lock_cnt_q == LOCK_LAST) || (host_gnt && !host_lock)) begin
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // FSM and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB;
         starve_cnt_q <= '0;
         lock_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   assign locked      = (state_q == HOST_LOCKED);
   assign cpu_rd_acc  = cpu_gnt && !cpu_we;
   assign host_rd_acc = host_gnt && !host_we;

   arb_rd_tracker #(.DATA_W(DATA_W)) u_cpu_rd (
      .clk       (clk),
      .rst       (rst),
      .rd_accept (cpu_rd_acc),
      .ram_rdata (ram_rdata),
      .rvalid    (cpu_rvalid),
      .rdata     (cpu_rdata)
   );

   arb_rd_tracker #(.DATA_W(DATA_W)) u_host_rd (
      .clk       (clk),
      .rst       (rst),
      .rd_accept (host_rd_acc),
      .ram_rdata (ram_rdata),
      .rvalid    (host_rvalid),
      .rdata     (host_rdata)
   );

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a read
// response scoreboard.
module tb_ram_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          host_req, host_we, host_lock;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt, host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          locked;

   int tests_run;
   int tests_failed;
   int cyc;

   typedef struct {
      bit          port;   // 0 = cpu, 1 = host
      logic [31:0] data;
      int          cyc;
   } rsp_t;

   rsp_t        sbq[$];
   logic [31:0] sb_mem  [32] = '{default: '0};
   logic [31:0] ram_mem [32] = '{default: '0};

   ram_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_WAIT (4),
      .LOCK_MAX (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_gnt     (cpu_gnt),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_lock   (host_lock),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .locked      (locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM: synchronous write, one-cycle registered read
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   // monitor: response scoreboard, mutual exclusion and RAM bus routing
   always @(negedge clk) begin
      bit          due, ecv, ehv;
      logic [31:0] ecd, ehd;
      logic        ewe;
      logic [4:0]  eaddr;
      logic [31:0] ewd;
      rsp_t        r;
      cyc = cyc + 1;
      if (rst) begin
         sbq.delete();
      end else begin
         due = 1'b0; ecv = 1'b0; ehv = 1'b0; ecd = '0; ehd = '0;
         if (sbq.size() > 0) begin
            if (sbq[0].cyc == cyc - 1) due = 1'b1;
         end
         if (due) begin
            r = sbq.pop_front();
            if (r.port) begin ehv = 1'b1; ehd = r.data; end
            else        begin ecv = 1'b1; ecd = r.data; end
         end
         tests_run++;
         if (cpu_rvalid !== ecv || cpu_rdata !== ecd) begin
            tests_failed++;
            $display("FAIL cpu_rsp cyc %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                     cyc, cpu_rvalid, cpu_rdata, ecv, ecd);
         end
         tests_run++;
         if (host_rvalid !== ehv || host_rdata !== ehd) begin
            tests_failed++;
            $display("FAIL host_rsp cyc %0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                     cyc, host_rvalid, host_rdata, ehv, ehd);
         end
         tests_run++;
         if (cpu_gnt === 1'b1 && host_gnt === 1'b1) begin
            tests_failed++;
            $display("FAIL mutex cyc %0d: got cpu_gnt=1 host_gnt=1, expected at most one", cyc);
         end
         ewe = 1'b0; eaddr = '0; ewd = '0;
         if (cpu_req && cpu_gnt) begin
            ewe = cpu_we; eaddr = cpu_addr; ewd = cpu_wdata;
         end else if (host_req && host_gnt) begin
            ewe = host_we; eaddr = host_addr; ewd = host_wdata;
         end
         tests_run++;
         if (ram_we !== ewe || ram_addr !== eaddr || ram_wdata !== ewd) begin
            tests_failed++;
            $display("FAIL ram_bus cyc %0d: got we=%b addr=%0d wdata=%h, expected we=%b addr=%0d wdata=%h",
                     cyc, ram_we, ram_addr, ram_wdata, ewe, eaddr, ewd);
         end
         if (cpu_req && cpu_gnt) begin
            if (cpu_we) sb_mem[cpu_addr] = cpu_wdata;
            else sbq.push_back('{port: 1'b0, data: sb_mem[cpu_addr], cyc: cyc});
         end
         if (host_req && host_gnt) begin
            if (host_we) sb_mem[host_addr] = host_wdata;
            else sbq.push_back('{port: 1'b1, data: sb_mem[host_addr], cyc: cyc});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_addr = '0; host_wdata = '0;
   endtask

   task automatic test_reset();
      logic [199:0] outs;
      repeat (2) tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
      @(negedge clk);
      outs = {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, ram_we, locked, ram_addr,
              ram_wdata, cpu_rdata, host_rdata};
      tests_run++;
      if (outs !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, expected 0", outs);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_gnt: got cpu_gnt=%b, expected 1", cpu_gnt);
      end
      tick();
      rst = 1'b1; cpu_req = 1'b0;
      @(negedge clk);
      outs = {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, ram_we, locked, ram_addr,
              ram_wdata, cpu_rdata, host_rdata};
      tests_run++;
      if (outs !== '0) begin
         tests_failed++;
         $display("FAIL reset_midread: got %h, expected 0", outs);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cpu_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_no_late_rsp: got cpu_rvalid=%b, expected 0", cpu_rvalid);
      end
   endtask

   task automatic test_write_read_cpu();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'd5 || ram_wdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL wr_cycle1: got gnt=%b we=%b addr=%0d wdata=%h, expected 1 1 5 deadbeef",
                  cpu_gnt, ram_we, ram_addr, ram_wdata);
      end
      tick();
      cpu_we = 1'b0; cpu_wdata = '0;
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== 1'b1 || ram_we !== 1'b0 || host_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_cycle2: got gnt=%b we=%b host_rvalid=%b, expected 1 0 0",
                  cpu_gnt, ram_we, host_rvalid);
      end
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || host_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_cycle3: got rvalid=%b rdata=%h host_rvalid=%b, expected 1 deadbeef 0",
                  cpu_rvalid, cpu_rdata, host_rvalid);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_starvation();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd2; cpu_wdata = 32'h0BADF00D;
      tick();
      cpu_we = 1'b0; cpu_addr = 5'd9; cpu_wdata = '0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd2;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         tests_run++;
         if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL starve_cpu_win %0d: got cpu_gnt=%b host_gnt=%b, expected 1 0",
                     k, cpu_gnt, host_gnt);
         end
         tick();
      end
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== 1'b0 || host_gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_host_win: got cpu_gnt=%b host_gnt=%b, expected 0 1", cpu_gnt, host_gnt);
      end
      tick();
      host_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (host_rvalid !== 1'b1 || host_rdata !== 32'h0BADF00D || cpu_gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_after: got host_rvalid=%b host_rdata=%h cpu_gnt=%b, expected 1 0badf00d 1",
                  host_rvalid, host_rdata, cpu_gnt);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_lock_burst();
      int n;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
      for (int i = 0; i < 4; i++) begin
         host_req = 1'b1; host_we = 1'b0; host_addr = 5'(i); host_lock = (i < 3);
         n = 0;
         @(negedge clk);
         while (host_gnt !== 1'b1 && n < 20) begin
            tick();
            @(negedge clk);
            n++;
         end
         tests_run++;
         if (host_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_burst_timeout %0d: got no host_gnt in 20 cycles, expected a grant", i);
         end else if (i > 0 && (n != 0 || locked !== 1'b1 || cpu_gnt !== 1'b0)) begin
            tests_failed++;
            $display("FAIL lock_burst_grant %0d: got wait=%0d locked=%b cpu_gnt=%b, expected 0 1 0",
                     i, n, locked, cpu_gnt);
         end else if (i == 0 && locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_burst_first: got locked=%b, expected 0", locked);
         end
         tick();
      end
      host_req = 1'b0; host_lock = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== 1'b1 || locked !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_burst_release: got cpu_gnt=%b locked=%b, expected 1 0", cpu_gnt, locked);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_lock_timeout();
      int n;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd9;
      host_req = 1'b1; host_we = 1'b0; host_lock = 1'b1; host_addr = 5'd4;
      n = 0;
      @(negedge clk);
      while (host_gnt !== 1'b1 && n < 20) begin
         tick();
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (host_gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_to_enter: got no host_gnt in 20 cycles, expected a grant");
      end
      for (int k = 1; k <= 16; k++) begin
         tick();
         host_req = (k % 2 == 1);
         host_addr = 5'(k);
         @(negedge clk);
         tests_run++;
         if (locked !== 1'b1 || cpu_gnt !== 1'b0 || host_gnt !== host_req) begin
            tests_failed++;
            $display("FAIL lock_to_hold %0d: got locked=%b cpu_gnt=%b host_gnt=%b, expected 1 0 %b",
                     k, locked, cpu_gnt, host_gnt, host_req);
         end
      end
      tick();
      host_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (locked !== 1'b0 || cpu_gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_to_release: got locked=%b cpu_gnt=%b, expected 0 1", locked, cpu_gnt);
      end
      // reset while locked
      tick();
      cpu_req = 1'b0; host_req = 1'b1; host_lock = 1'b1; host_addr = 5'd3;
      @(negedge clk);
      tick();
      host_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (locked !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_rst_enter: got locked=%b, expected 1", locked);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (locked !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_rst_clear: got locked=%b, expected 0", locked);
      end
      tick();
      rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
      @(negedge clk);
      tests_run++;
      if (cpu_gnt !== 1'b1 || locked !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_rst_after: got cpu_gnt=%b locked=%b, expected 1 0", cpu_gnt, locked);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      bit cpu_acc, host_acc;
      int host_wait;
      cpu_acc = 1'b0; host_acc = 1'b0; host_wait = 0;
      for (int i = 0; i < 10000; i++) begin
         tick();
         if (cpu_acc) cpu_req = 1'b0;
         if (host_acc) host_req = 1'b0;
         if (!cpu_req && $urandom_range(0, 1) == 1) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 5'($urandom_range(0, 31)); cpu_wdata = $urandom;
         end
         if (!host_req && $urandom_range(0, 1) == 1) begin
            host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
            host_lock = ($urandom_range(0, 3) == 0);
            host_addr = 5'($urandom_range(0, 31)); host_wdata = $urandom;
         end
         @(negedge clk);
         cpu_acc  = cpu_req && cpu_gnt;
         host_acc = host_req && host_gnt;
         if (host_acc) begin
            tests_run++;
            if (host_wait > 4) begin
               tests_failed++;
               $display("FAIL host_starved: got wait=%0d cycles, expected at most 4", host_wait);
            end
            host_wait = 0;
         end else if (host_req) begin
            host_wait++;
         end
      end
      tick();
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_ram_contents();
      for (int a = 0; a < 32; a++) begin
         tests_run++;
         if (ram_mem[a] !== sb_mem[a]) begin
            tests_failed++;
            $display("FAIL ram_content addr %0d: got %h, expected %h", a, ram_mem[a], sb_mem[a]);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      cyc = 0;
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_write_read_cpu();
      test_starvation();
      test_lock_burst();
      test_lock_timeout();
      test_random();
      test_ram_contents();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
